// File: rtl/ckpt_free_list_pkg.sv
// Shared types for the R10K physical-register free list and its
// head-pointer checkpoint store.
package ckpt_free_list_pkg;
    localparam int PHYS_REG_SZ_R10K = 64;
    localparam int ARCH_REG_SZ      = 32;
    localparam int N                = 3;
    localparam int NUM_CKPT_DEFAULT = 4;

    localparam int PRN_W = $clog2(PHYS_REG_SZ_R10K);

    typedef logic [PRN_W-1:0] PRN;

    typedef struct packed {
        logic valid;
        PRN   prn;
    } FREE_LIST_PACKET;

    typedef logic [$clog2(NUM_CKPT_DEFAULT)-1:0] CKPT_ID;
    typedef logic [PRN_W:0]                      FL_PTR;
endpackage

// File: rtl/ckpt_fifo.sv
// Circular store of head-pointer snapshots: take at the young end, retire at
// the old end, restore truncates back to (and frees) the restored slot.
module ckpt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 7
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     take,
    input  logic [W-1:0]             take_data,
    input  logic                     retire,
    input  logic                     restore,
    input  logic [$clog2(DEPTH)-1:0] restore_id,
    output logic [W-1:0]             restore_data,
    output logic                     restore_hit,
    output logic [$clog2(DEPTH)-1:0] take_id,
    output logic                     avail,
    output logic                     err
);
    localparam int IW = $clog2(DEPTH);

    logic [IW:0]  old_reg, new_reg, old_next, new_next;
    logic [IW:0]  used, offset;
    logic [W-1:0] slot [DEPTH];
    logic         full, empty, take_ok, retire_ok;

    assign used         = new_reg - old_reg;
    assign full         = (used == (IW+1)'(DEPTH));
    assign empty        = (used == '0);
    // Age of the restored slot relative to the oldest live checkpoint.
    assign offset       = {1'b0, restore_id - old_reg[IW-1:0]};
    assign restore_hit  = restore && (offset < used);
    assign restore_data = slot[restore_id];
    assign take_id      = new_reg[IW-1:0];
    assign avail        = !full;
    assign take_ok      = take && !full;
    assign retire_ok    = retire && !empty && !(restore_hit && offset == '0);
    assign err          = (take && full) || (retire && empty) || (restore && !restore_hit);

    always_comb begin
        old_next = old_reg;
        new_next = new_reg;
        if (retire_ok)
            old_next = old_reg + 1'b1;
        if (restore_hit)
            new_next = old_reg + offset;
        else if (take_ok)
            new_next = new_reg + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            old_reg <= '0;
            new_reg <= '0;
        end else begin
            old_reg <= old_next;
            new_reg <= new_next;
        end
    end

    always_ff @(posedge clock) begin
        if (take_ok && !restore)
            slot[take_id] <= take_data;
    end
endmodule

// File: rtl/ckpt_free_list.sv
// R10K free list: circular PRN FIFO with all-or-nothing multi-lane pop,
// multi-lane push and head checkpoints restored by ID in one cycle.
module ckpt_free_list
    import ckpt_free_list_pkg::*;
#(
    parameter int SIZE     = PHYS_REG_SZ_R10K,
    parameter int ARCH_SZ  = ARCH_REG_SZ,
    parameter int N_POP    = N,
    parameter int N_PUSH   = N,
    parameter int NUM_CKPT = NUM_CKPT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [N_POP-1:0]      pop_req,
    output FREE_LIST_PACKET       pop_packet [N_POP],
    output logic                  pop_grant,
    input  FREE_LIST_PACKET       push_packet [N_PUSH],
    input  logic                  ckpt_take,
    output CKPT_ID                ckpt_take_id,
    output logic                  ckpt_avail,
    input  logic                  ckpt_retire,
    input  logic                  restore_valid,
    input  CKPT_ID                restore_id,
    output logic [$clog2(SIZE):0] free_count,
    output logic                  error
);
    localparam int IW = $clog2(SIZE);
    localparam int PW = IW + 1;

    PRN            entries [SIZE];
    logic [PW-1:0] head_reg, tail_reg, free_count_reg;
    logic [PW-1:0] head_pop, head_next, tail_next;
    logic [PW-1:0] pop_off [N_POP+1];
    logic [PW-1:0] push_off [N_PUSH+1];
    logic [IW-1:0] push_idx [N_PUSH];
    logic [PW:0]   used_after;
    logic [PW-1:0] snap_head;
    logic          error_reg, grant, push_drop, restore_hit, fifo_err;

    // Prefix popcounts give each lane its offset from head / tail.
    assign pop_off[0]  = '0;
    assign push_off[0] = '0;
    for (genvar gi = 0; gi < N_POP; gi++) begin : g_pop
        logic [IW-1:0] idx;
        assign pop_off[gi+1]         = pop_off[gi] + PW'(pop_req[gi]);
        assign idx                   = head_reg[IW-1:0] + pop_off[gi][IW-1:0];
        assign pop_packet[gi].valid  = grant && pop_req[gi];
        assign pop_packet[gi].prn    = (grant && pop_req[gi]) ? entries[idx] : '0;
    end
    for (genvar gi = 0; gi < N_PUSH; gi++) begin : g_push
        assign push_off[gi+1] = push_off[gi] + PW'(push_packet[gi].valid);
        assign push_idx[gi]   = tail_reg[IW-1:0] + push_off[gi][IW-1:0];
    end

    assign grant     = reset_n && !restore_valid && (pop_off[N_POP] != '0)
                       && (free_count_reg >= pop_off[N_POP]);
    assign pop_grant = grant;
    assign head_pop  = grant ? head_reg + pop_off[N_POP] : head_reg;
    assign head_next = restore_hit ? snap_head : head_pop;

    // A push group that would overfill the list is dropped as a whole.
    assign used_after = {1'b0, tail_reg - head_next} + {1'b0, push_off[N_PUSH]};
    assign push_drop  = used_after > (PW+1)'(SIZE);
    assign tail_next  = push_drop ? tail_reg : tail_reg + push_off[N_PUSH];

    ckpt_fifo #(
        .DEPTH (NUM_CKPT),
        .W     (PW)
    ) u_ckpt (
        .clock        (clock),
        .reset_n      (reset_n),
        .take         (ckpt_take && !restore_valid),
        .take_data    (head_pop),
        .retire       (ckpt_retire),
        .restore      (restore_valid),
        .restore_id   (restore_id),
        .restore_data (snap_head),
        .restore_hit  (restore_hit),
        .take_id      (ckpt_take_id),
        .avail        (ckpt_avail),
        .err          (fifo_err)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SIZE; i++)
                entries[i] <= PRN'(i);
            head_reg       <= PW'(ARCH_SZ);
            tail_reg       <= PW'(SIZE);
            free_count_reg <= PW'(SIZE - ARCH_SZ);
            error_reg      <= 1'b0;
        end else begin
            for (int i = 0; i < N_PUSH; i++)
                if (push_packet[i].valid && !push_drop)
                    entries[push_idx[i]] <= push_packet[i].prn;
            head_reg       <= head_next;
            tail_reg       <= tail_next;
            free_count_reg <= tail_next - head_next;
            error_reg      <= error_reg || fifo_err || push_drop;
        end
    end

    assign free_count = free_count_reg;
    assign error      = error_reg;
endmodule

// File: tb/tb_ckpt_free_list.sv
// Directed bench for ckpt_free_list (SIZE 64, ARCH 32, 3 lanes, 4 checkpoints).
module tb_ckpt_free_list;
    import ckpt_free_list_pkg::*;

    logic            clk;
    logic            reset_n;
    logic [2:0]      pop_req;
    FREE_LIST_PACKET pop_packet [3];
    logic            pop_grant;
    FREE_LIST_PACKET push_packet [3];
    logic            ckpt_take;
    CKPT_ID          ckpt_take_id;
    logic            ckpt_avail;
    logic            ckpt_retire;
    logic            restore_valid;
    CKPT_ID          restore_id;
    logic [6:0]      free_count;
    logic            error;

    int vectors = 0;
    int miscompares = 0;
    int q[$];
    int pv = 0;

    ckpt_free_list dut (
        .clock         (clk),
        .reset_n       (reset_n),
        .pop_req       (pop_req),
        .pop_packet    (pop_packet),
        .pop_grant     (pop_grant),
        .push_packet   (push_packet),
        .ckpt_take     (ckpt_take),
        .ckpt_take_id  (ckpt_take_id),
        .ckpt_avail    (ckpt_avail),
        .ckpt_retire   (ckpt_retire),
        .restore_valid (restore_valid),
        .restore_id    (restore_id),
        .free_count    (free_count),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [2:0] m, input int p0, input int p1, input int p2);
        logic [20:0] obs;
        logic [20:0] exp;
        int p[3];
        p = '{p0, p1, p2};
        for (int i = 0; i < 3; i++) begin
            obs[i*7 +: 7] = {pop_packet[i].valid, pop_packet[i].prn};
            exp[i*7 +: 7] = m[i] ? {1'b1, PRN'(p[i])} : 7'd0;
        end
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed lanes %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pop_req       = '0;
        ckpt_take     = 1'b0;
        ckpt_retire   = 1'b0;
        restore_valid = 1'b0;
        restore_id    = '0;
        for (int i = 0; i < 3; i++) push_packet[i] = '0;
    endtask

    task automatic push(input logic [2:0] m, input int a, input int b, input int c);
        int v[3];
        v = '{a, b, c};
        for (int i = 0; i < 3; i++)
            push_packet[i] = m[i] ? '{valid: 1'b1, prn: PRN'(v[i])} : '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #12 reset_n = 1'b1;
        tick();

        // reset state
        chk("rst_free", free_count, 32);
        chk("rst_avail", ckpt_avail, 1);
        chk("rst_take_id", ckpt_take_id, 0);
        chk("rst_error", error, 0);
        chk("rst_grant", pop_grant, 0);

        // first group pop
        pop_req = 3'b111; #1;
        chk_pop("pop_first", 3'b111, 32, 33, 34);
        chk("pop_first_grant", pop_grant, 1);
        tick();
        chk("free_29", free_count, 29);

        // drain to two free
        for (int i = 0; i < 9; i++) begin
            pop_req = 3'b111; #1;
            chk_pop("drain", 3'b111, 35 + 3*i, 36 + 3*i, 37 + 3*i);
            tick();
        end
        chk("free_2", free_count, 2);

        pop_req = 3'b111; #1;
        chk("nogrant", pop_grant, 0);
        chk_pop("nogrant_lanes", 3'b000, 0, 0, 0);
        tick();
        chk("free_2_hold", free_count, 2);

        pop_req = 3'b101; #1;
        chk_pop("sparse_pop", 3'b101, 62, 0, 63);
        chk("sparse_grant", pop_grant, 1);
        tick();
        chk("free_0", free_count, 0);

        // refill; pushed PRNs cannot be popped in the push cycle
        pop_req = 3'b001;
        push(3'b111, 32, 33, 34); #1;
        chk("push_same_cycle", pop_grant, 0);
        tick();
        pop_req = '0;
        push(3'b111, 35, 36, 37); tick();
        push(3'b111, 38, 39, 40); tick();
        push(3'b111, 41, 42, 43); tick();
        idle();
        chk("free_12", free_count, 12);

        // checkpoint, speculate, restore with concurrent push
        pop_req = 3'b111; ckpt_take = 1'b1; #1;
        chk("take_id0", ckpt_take_id, 0);
        chk_pop("pop_wrap", 3'b111, 32, 33, 34);
        tick();
        idle();
        chk("free_9", free_count, 9);
        chk("take_id1", ckpt_take_id, 1);
        pop_req = 3'b111; tick();
        pop_req = 3'b111; tick();
        chk("free_3", free_count, 3);
        pop_req = 3'b111; restore_valid = 1'b1; restore_id = 0;
        push(3'b011, 50, 51, 0); #1;
        chk("restore_grant", pop_grant, 0);
        chk_pop("restore_lanes", 3'b000, 0, 0, 0);
        tick();
        idle();
        chk("restore_free", free_count, 11);
        chk("restore_take_id", ckpt_take_id, 0);
        chk("restore_error", error, 0);

        // fill checkpoint store
        for (int i = 0; i < 4; i++) begin
            ckpt_take = 1'b1; #1;
            chk("fill_take_id", ckpt_take_id, i);
            tick();
        end
        chk("full_avail", ckpt_avail, 0);
        chk("full_take_id", ckpt_take_id, 0);
        chk("full_error", error, 0);
        tick();
        chk("overtake_error", error, 1);
        chk("overtake_take_id", ckpt_take_id, 0);
        ckpt_take = 1'b0; ckpt_retire = 1'b1; tick();
        chk("retire_avail", ckpt_avail, 1);
        chk("retire_take_id", ckpt_take_id, 0);

        // restore of the oldest together with retire empties the store
        restore_valid = 1'b1; restore_id = 1; tick();
        idle();
        chk("rr_take_id", ckpt_take_id, 1);
        chk("rr_free", free_count, 11);
        for (int i = 0; i < 3; i++) begin
            ckpt_take = 1'b1; tick();
        end
        chk("rr_avail_3", ckpt_avail, 1);
        tick();
        chk("rr_avail_4", ckpt_avail, 0);
        idle();

        // steady pop-3/push-3 streaming across many wraps
        for (int v = 35; v <= 43; v++) q.push_back(v);
        q.push_back(50);
        q.push_back(51);
        for (int c = 0; c < 200; c++) begin
            pop_req = 3'b111;
            push(3'b111, pv % 64, (pv + 1) % 64, (pv + 2) % 64);
            #1;
            chk_pop("stream", 3'b111, q[0], q[1], q[2]);
            void'(q.pop_front());
            void'(q.pop_front());
            void'(q.pop_front());
            q.push_back(pv % 64);
            q.push_back((pv + 1) % 64);
            q.push_back((pv + 2) % 64);
            pv += 3;
            tick();
            chk("stream_free", free_count, 11);
        end
        chk("stream_error_sticky", error, 1);

        // asynchronous reset between edges
        pop_req = 3'b111; push(3'b000, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_free", free_count, 32);
        chk("arst_grant", pop_grant, 0);
        chk_pop("arst_lanes", 3'b000, 0, 0, 0);
        chk("arst_error", error, 0);
        chk("arst_avail", ckpt_avail, 1);
        chk("arst_take_id", ckpt_take_id, 0);
        tick();
        reset_n = 1'b1; #1;
        chk_pop("post_rst_pop", 3'b111, 32, 33, 34);
        chk("post_rst_grant", pop_grant, 1);
        tick();
        chk("post_rst_free", free_count, 29);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
